pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_pkg.sv | 15 +
 rtl/pulse_train_ch.sv | 160 ++++++++++++++++
 rtl/pulse_train_gen.sv | 90 +++++++++
 tb/tb_pulse_train_gen.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_train_pkg.sv
// Shared types and default widths for the pulse train generator.
package pulse_train_pkg;

    // Per-channel FSM state, also exported on the channel debug output
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } pt_state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 32;
    localparam int DEF_REP_W  = 16;

endpackage

// File: rtl/pulse_train_ch.sv
// One pulse train channel: start edge detect, config latch, IDLE/DELAY/PULSE
// FSM with delay/width down-counter and repetition counter.
// Handshake: none; start is a level whose rising edge is accepted only in
// IDLE, abort is a level that wins over everything on the next clock edge.
module pulse_train_ch
    import pulse_train_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int REP_W   = DEF_REP_W,
    parameter int ARM_CYC = 1  // clocks after reset before start edges count
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_delay_cycles,
    input  logic [CNT_W-1:0] i_width_cycles,
    input  logic [REP_W-1:0] i_repetition,
    input  logic             i_polarity,
    output logic             o_pulse,
    output logic             o_done,
    output pt_state_e        o_state
);

    localparam int ARM_W = $clog2(ARM_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    pt_state_e        r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [REP_W-1:0] r_rep, w_rep_nx;
    logic [CNT_W-1:0] r_delay, r_width;
    logic             r_pol;
    logic             r_done, w_done_nx;
    logic             r_start_prev;
    logic [ARM_W-1:0] r_arm;
    logic             w_armed;
    logic             w_start_edge;
    logic             w_accept;

    // A start level still high when reset releases must not look like an edge,
    // so edges are ignored until the input path has been sampled after reset.
    assign w_armed      = (r_arm == ARM_W'(ARM_CYC));
    assign w_start_edge = i_start & ~r_start_prev & w_armed;
    assign w_accept     = (r_state == IDLE) & w_start_edge & ~i_abort;

    // Edge detector history and post-reset arming counter
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_start_prev <= 1'b0;
            r_arm        <= '0;
        end else begin
            r_start_prev <= i_start;
            if (!w_armed) r_arm <= r_arm + ARM_W'(1);
        end
    end

    // Latch the train configuration when a start is accepted
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_delay <= '0;
            r_width <= '0;
            r_pol   <= 1'b0;
        end else if (w_accept) begin
            r_delay <= i_delay_cycles;
            r_width <= i_width_cycles;
            r_pol   <= i_polarity;
        end
    end

    // FSM state, counters and done strobe registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rep   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_rep   <= w_rep_nx;
            r_done  <= w_done_nx;
        end
    end

    // Next-state logic; r_cnt holds the cycles left in the current phase and
    // r_rep the pulses left (0 = continuous, never decremented)
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_rep_nx   = r_rep;
        w_done_nx  = 1'b0;
        if (i_abort) begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
            w_rep_nx   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        w_rep_nx = i_repetition;
                        // A zero width still spends one DELAY cycle so the
                        // channel reports busy once before signalling done.
                        if ((i_width_cycles == '0) || (i_delay_cycles != '0)) begin
                            w_state_nx = DELAY;
                            w_cnt_nx   = i_delay_cycles;
                        end else begin
                            w_state_nx = PULSE;
                            w_cnt_nx   = i_width_cycles;
                        end
                    end
                end
                DELAY: begin
                    if (r_width == '0) begin
                        w_state_nx = IDLE;
                        w_cnt_nx   = '0;
                        w_rep_nx   = '0;
                        w_done_nx  = 1'b1;
                    end else if (r_cnt <= CNT_ONE) begin
                        w_state_nx = PULSE;
                        w_cnt_nx   = r_width;
                    end else begin
                        w_cnt_nx = r_cnt - CNT_ONE;
                    end
                end
                PULSE: begin
                    if (r_cnt <= CNT_ONE) begin
                        if (r_rep == REP_ONE) begin
                            w_state_nx = IDLE;
                            w_cnt_nx   = '0;
                            w_rep_nx   = '0;
                            w_done_nx  = 1'b1;
                        end else begin
                            if (r_rep != '0) w_rep_nx = r_rep - REP_ONE;
                            if (r_delay != '0) begin
                                w_state_nx = DELAY;
                                w_cnt_nx   = r_delay;
                            end else begin
                                w_state_nx = PULSE;
                                w_cnt_nx   = r_width;
                            end
                        end
                    end else begin
                        w_cnt_nx = r_cnt - CNT_ONE;
                    end
                end
                default: begin
                    w_state_nx = IDLE;
                    w_cnt_nx   = '0;
                    w_rep_nx   = '0;
                end
            endcase
        end
    end

    assign o_pulse = (r_state == IDLE) ? i_polarity : ((r_state == PULSE) ^ r_pol);
    assign o_done  = r_done;
    assign o_state = r_state;

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator: NUM_CH independent pulse_train_ch
// instances plus activity LEDs. Define PULSE_TRAIN_GEN_SYNC_EN to pass start
// and abort through 2-flop synchronizers (adds 2 clocks to every response).
module pulse_train_gen
    import pulse_train_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int REP_W  = DEF_REP_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_CH-1:0]            start,
    input  logic [NUM_CH-1:0]            abort,
    input  logic [NUM_CH-1:0][CNT_W-1:0] delay_cycles,
    input  logic [NUM_CH-1:0][CNT_W-1:0] width_cycles,
    input  logic [NUM_CH-1:0][REP_W-1:0] repetition,
    input  logic [NUM_CH-1:0]            polarity,
    output logic [NUM_CH-1:0]            pulse_out,
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH-1:0]            done,
    output logic                         delay_led,
    output logic                         pulse_led
);

    logic [NUM_CH-1:0] w_start;
    logic [NUM_CH-1:0] w_abort;
    logic [NUM_CH-1:0] w_in_delay;
    logic [NUM_CH-1:0] w_in_pulse;
    pt_state_e         w_state [NUM_CH];

`ifdef PULSE_TRAIN_GEN_SYNC_EN
    // Two extra sampled clocks before a held start can be seen as an edge
    localparam int ARM_CYC = 3;

    logic [NUM_CH-1:0] r_start_s1, r_start_s2;
    logic [NUM_CH-1:0] r_abort_s1, r_abort_s2;

    // Two-flop synchronizers on the asynchronous control levels
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_start_s1 <= '0;
            r_start_s2 <= '0;
            r_abort_s1 <= '0;
            r_abort_s2 <= '0;
        end else begin
            r_start_s1 <= start;
            r_start_s2 <= r_start_s1;
            r_abort_s1 <= abort;
            r_abort_s2 <= r_abort_s1;
        end
    end

    assign w_start = r_start_s2;
    assign w_abort = r_abort_s2;
`else
    localparam int ARM_CYC = 1;

    assign w_start = start;
    assign w_abort = abort;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_train_ch #(
            .CNT_W  (CNT_W),
            .REP_W  (REP_W),
            .ARM_CYC(ARM_CYC)
        ) u_ch (
            .i_clk          (clk),
            .i_reset_n      (reset_n),
            .i_start        (w_start[g]),
            .i_abort        (w_abort[g]),
            .i_delay_cycles (delay_cycles[g]),
            .i_width_cycles (width_cycles[g]),
            .i_repetition   (repetition[g]),
            .i_polarity     (polarity[g]),
            .o_pulse        (pulse_out[g]),
            .o_done         (done[g]),
            .o_state        (w_state[g])
        );

        assign busy[g]       = (w_state[g] != IDLE);
        assign w_in_delay[g] = (w_state[g] == DELAY);
        assign w_in_pulse[g] = (w_state[g] == PULSE);
    end

    assign delay_led = |w_in_delay;
    assign pulse_led = |w_in_pulse;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen (NUM_CH = 4, synchronizers off).
// Expected per-cycle frames come from a timing model of the pulse trains.
module tb_pulse_train_gen;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
    localparam int REP_W  = 16;
    localparam int W      = 14;  // {busy[3:0], done[3:0], pulse_out[3:0], delay_led, pulse_led}
    localparam int MAXN   = 16;

    // ---------------- clock / reset / DUT ----------------
    logic                         clk = 1'b0;
    logic                         reset_n;
    logic [NUM_CH-1:0]            start;
    logic [NUM_CH-1:0]            abort;
    logic [NUM_CH-1:0][CNT_W-1:0] delay_cycles;
    logic [NUM_CH-1:0][CNT_W-1:0] width_cycles;
    logic [NUM_CH-1:0][REP_W-1:0] repetition;
    logic [NUM_CH-1:0]            polarity;
    logic [NUM_CH-1:0]            pulse_out;
    logic [NUM_CH-1:0]            busy;
    logic [NUM_CH-1:0]            done;
    logic                         delay_led;
    logic                         pulse_led;

    always #5 clk = ~clk;

    pulse_train_gen #(
        .NUM_CH(NUM_CH),
        .CNT_W (CNT_W),
        .REP_W (REP_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .delay_cycles(delay_cycles),
        .width_cycles(width_cycles),
        .repetition  (repetition),
        .polarity    (polarity),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .delay_led   (delay_led),
        .pulse_led   (pulse_led)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           vectors     = 0;
    int           miscompares = 0;

    // per-channel expected trace: {busy, done, pulse_out, in_delay, in_pulse}
    logic [4:0]   tr [NUM_CH][MAXN];

    // Every channel idle, showing its current polarity input
    task automatic clear_tr(input int n);
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int k = 0; k < n; k++)
                tr[ch][k] = {1'b0, 1'b0, polarity[ch], 1'b0, 1'b0};
    endtask

    // Timing model of one train: cycle k = k-th cycle after the accepting edge
    task automatic model_ch(input int ch, input int d, input int w, input int rep,
                            input logic pol, input int n);
        int   total;
        logic bz, dn, raw, po;
        total = (rep == 0) ? (1 << 30) : rep * (d + w);
        for (int k = 1; k <= n; k++) begin
            if (w == 0) begin
                bz  = (k == 1);
                dn  = (k == 2);
                raw = 1'b0;
            end else begin
                bz  = (k <= total);
                dn  = (k == total + 1);
                raw = bz && (((k - 1) % (d + w)) >= d);
            end
            po = bz ? (raw ^ pol) : pol;
            tr[ch][k-1] = {bz, dn, po, bz & ~raw, bz & raw};
        end
    endtask

    task automatic push_frames(input int n);
        logic [W-1:0] f;
        for (int k = 0; k < n; k++) begin
            f = '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                f[10+ch] = tr[ch][k][4];
                f[6+ch]  = tr[ch][k][3];
                f[2+ch]  = tr[ch][k][2];
                f[1]     = f[1] | tr[ch][k][1];
                f[0]     = f[0] | tr[ch][k][0];
            end
            exp_q.push_back(f);
        end
    endtask

    task automatic check_one(input string tag);
        logic [W-1:0] obs, exp_v;
        obs = {busy, done, pulse_out, delay_led, pulse_led};
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL %s: scoreboard empty, got %h", tag, obs);
        end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                miscompares++;
                $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic run_check(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_one(tag);
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        clear_tr(n);
        push_frames(n);
        run_check(n, tag);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- directed sequence ----------------
    initial begin
        reset_n      = 1'b0;
        start        = '0;
        abort        = '0;
        delay_cycles = '0;
        width_cycles = '0;
        repetition   = '0;
        polarity     = 4'b0110;

        // reset values, pulse_out follows polarity during reset
        #1;
        clear_tr(1); push_frames(1); check_one("reset_pol0110");
        polarity = 4'b1001;
        #1;
        clear_tr(1); push_frames(1); check_one("reset_pol1001");
        @(negedge clk);
        clear_tr(1); push_frames(1); check_one("reset_held");
        polarity = 4'b0000;
        reset_n  = 1'b1;
        idle_check(2, "post_reset_idle");

        // ch0 solo: delay 3 width 2 rep 1; config/polarity changes and a
        // second start edge while busy must not disturb the train
        delay_cycles[0] = 3; width_cycles[0] = 2; repetition[0] = 1; start[0] = 1'b1;
        clear_tr(10);
        model_ch(0, 3, 2, 1, 1'b0, 10);
        for (int k = 5; k < 10; k++) tr[0][k][2] = 1'b1;  // idle shows new polarity
        push_frames(10);
        run_check(2, "ch0_solo");
        start[0] = 1'b0; delay_cycles[0] = 7; width_cycles[0] = 9; polarity[0] = 1'b1;
        run_check(1, "ch0_solo");
        start[0] = 1'b1;
        run_check(7, "ch0_busy_start");
        start[0] = 1'b0;
        idle_check(1, "gap");

        // ch1: delay 2 width 1 rep 3
        delay_cycles[1] = 2; width_cycles[1] = 1; repetition[1] = 3; start[1] = 1'b1;
        clear_tr(14); model_ch(1, 2, 1, 3, 1'b0, 14); push_frames(14);
        run_check(14, "ch1_rep3");
        start[1] = 1'b0;
        idle_check(1, "gap");

        // ch2: zero width ends at once; zero delay pulses in first busy cycle
        delay_cycles[2] = 0; width_cycles[2] = 0; repetition[2] = 5; start[2] = 1'b1;
        clear_tr(4); model_ch(2, 0, 0, 5, 1'b0, 4); push_frames(4);
        run_check(4, "ch2_width0");
        start[2] = 1'b0;
        idle_check(1, "gap");
        width_cycles[2] = 4; repetition[2] = 1; start[2] = 1'b1;
        clear_tr(7); model_ch(2, 0, 4, 1, 1'b0, 7); push_frames(7);
        run_check(7, "ch2_delay0");
        start[2] = 1'b0;
        idle_check(1, "gap");

        // ch3: continuous train, aborted after 10 cycles
        delay_cycles[3] = 1; width_cycles[3] = 1; repetition[3] = 0; start[3] = 1'b1;
        clear_tr(14); model_ch(3, 1, 1, 0, 1'b0, 10); push_frames(14);
        run_check(10, "ch3_continuous");
        abort[3] = 1'b1;
        run_check(4, "ch3_abort");
        abort[3] = 1'b0; start[3] = 1'b0;
        idle_check(2, "gap");

        // all channels together, mixed polarity, re-start edge on ch1 while busy
        polarity = 4'b0101;
        delay_cycles[0] = 3; width_cycles[0] = 2; repetition[0] = 1;
        delay_cycles[1] = 2; width_cycles[1] = 1; repetition[1] = 3;
        delay_cycles[2] = 0; width_cycles[2] = 4; repetition[2] = 1;
        delay_cycles[3] = 1; width_cycles[3] = 3; repetition[3] = 2;
        start = 4'b1111;
        clear_tr(14);
        model_ch(0, 3, 2, 1, 1'b1, 14);
        model_ch(1, 2, 1, 3, 1'b0, 14);
        model_ch(2, 0, 4, 1, 1'b1, 14);
        model_ch(3, 1, 3, 2, 1'b0, 14);
        push_frames(14);
        run_check(1, "all_ch");
        start[1] = 1'b0;
        run_check(2, "all_ch");
        start[1] = 1'b1;
        run_check(11, "all_ch_busy_start");
        start = '0;
        idle_check(2, "gap");

        // abort wins over a start edge in the same cycle; held start is no edge
        start[0] = 1'b1; abort[0] = 1'b1;
        idle_check(2, "abort_over_start");
        abort[0] = 1'b0;
        idle_check(3, "held_start_no_edge");
        start[0] = 1'b0;
        idle_check(1, "gap");

        // asynchronous reset mid-pulse, start held through release
        polarity = 4'b0100;
        delay_cycles[0] = 1; width_cycles[0] = 5; repetition[0] = 1;
        delay_cycles[2] = 0; width_cycles[2] = 2; repetition[2] = 0;
        start = 4'b0101;
        clear_tr(3);
        model_ch(0, 1, 5, 1, 1'b0, 3);
        model_ch(2, 0, 2, 0, 1'b1, 3);
        push_frames(3);
        run_check(3, "pre_reset");
        #2;
        reset_n = 1'b0;
        #1;
        clear_tr(1); push_frames(1); check_one("reset_async");
        @(negedge clk);
        reset_n = 1'b1;
        idle_check(6, "start_held_release");
        start = '0;
        idle_check(2, "gap");

        // a genuine edge after reset still starts a train
        width_cycles[0] = 2; start[0] = 1'b1;
        clear_tr(6); model_ch(0, 1, 2, 1, 1'b0, 6); push_frames(6);
        run_check(6, "post_reset_train");
        start = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
